// File: rtl/ladybird_mem_access_seq.sv
// ladybird_mem_access_seq
//
// Debug-side sequencer. A single-byte host request is turned into a short
// RV32I stream for the core's injected-fetch port:
//   LUI  ADDR_REG, hi
//   ADDI ADDR_REG, ADDR_REG, lo
//   ADDI DATA_REG, x0, wdata        (writes only)
//   SB / LB through ADDR_REG
//   JAL  x0, JAL_OFFSET             (hands control back to the core)
// For reads, the byte reported by the core is returned to the host.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/ready/write/addr/wdata   host request channel
//   inst_valid/ready, inst     instruction channel toward the core
//   core_rdata_valid, core_rdata       loaded byte reported by the core
//   resp_valid/ready, resp_rdata       host response channel
//   busy                       high whenever a sequence is in flight
//
// All outputs come straight from flops. Their next values are decoded from
// the next state, so inst/inst_valid are stable for as long as the core
// withholds inst_ready.
module ladybird_mem_access_seq #(
  parameter logic [4:0]  ADDR_REG   = 5'd5,
  parameter logic [4:0]  DATA_REG   = 5'd6,
  parameter logic [20:0] JAL_OFFSET = 21'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  input  logic        core_rdata_valid,
  input  logic [7:0]  core_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LUI  = 3'd1,
    ST_ADDA = 3'd2,
    ST_ADDD = 3'd3,
    ST_MEM  = 3'd4,
    ST_JAL  = 3'd5,
    ST_WAIT = 3'd6,
    ST_RESP = 3'd7
  } state_t;

  // ---------------------------------------------------------------------
  // Instruction encoders
  // ---------------------------------------------------------------------

  // The upper part is bumped by addr[11] because the following ADDI
  // sign-extends its 12-bit immediate; the 20-bit add wraps on purpose.
  function automatic logic [31:0] enc_lui(input logic [31:0] addr);
    logic [19:0] hi;
    hi = addr[31:12] + {19'd0, addr[11]};
    return {hi, ADDR_REG, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_sb();
    return {7'b0000000, DATA_REG, ADDR_REG, 3'b000, 5'b00000, 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lb();
    return {12'h000, ADDR_REG, 3'b000, DATA_REG, 7'b0000011};
  endfunction

  // J-type immediate scrambling; offset bit 0 is never encoded.
  function automatic logic [31:0] enc_jal();
    return {JAL_OFFSET[20], JAL_OFFSET[10:1], JAL_OFFSET[11],
            JAL_OFFSET[19:12], 5'b00000, 7'b1101111};
  endfunction

  // ---------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------
  state_t      state_r, state_next_s;
  logic [31:0] addr_r;
  logic [7:0]  wdata_r;
  logic        write_r;
  logic [7:0]  rdata_r, rdata_next_s;

  logic        req_ready_r, inst_valid_r, resp_valid_r, busy_r;
  logic [31:0] inst_r;
  logic        inst_valid_next_s;
  logic [31:0] inst_next_s;

  logic        capture_s;
  logic [31:0] addr_s;
  logic [7:0]  wdata_s;
  logic        write_s;

  assign capture_s = (state_r == ST_IDLE) && req_valid && req_ready_r;

  // Request source: live request while capturing, latched copy afterwards.
  always_comb begin
    addr_s  = addr_r;
    wdata_s = wdata_r;
    write_s = write_r;
    if (state_r == ST_IDLE) begin
      addr_s  = req_addr;
      wdata_s = req_wdata;
      write_s = req_write;
    end else begin
      addr_s  = addr_r;
      wdata_s = wdata_r;
      write_s = write_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: if (capture_s) state_next_s = ST_LUI;
               else           state_next_s = ST_IDLE;
      ST_LUI:  if (inst_ready) state_next_s = ST_ADDA;
               else            state_next_s = ST_LUI;
      ST_ADDA: if (inst_ready) state_next_s = write_r ? ST_ADDD : ST_MEM;
               else            state_next_s = ST_ADDA;
      ST_ADDD: if (inst_ready) state_next_s = ST_MEM;
               else            state_next_s = ST_ADDD;
      ST_MEM:  if (inst_ready) state_next_s = ST_JAL;
               else            state_next_s = ST_MEM;
      ST_JAL:  if (inst_ready) state_next_s = write_r ? ST_RESP : ST_WAIT;
               else            state_next_s = ST_JAL;
      ST_WAIT: if (core_rdata_valid) state_next_s = ST_RESP;
               else                  state_next_s = ST_WAIT;
      ST_RESP: if (resp_ready) state_next_s = ST_IDLE;
               else            state_next_s = ST_RESP;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Instruction that the next state presents to the core.
  always_comb begin
    inst_next_s       = 32'h0000_0000;
    inst_valid_next_s = 1'b0;
    case (state_next_s)
      ST_LUI: begin
        inst_next_s       = enc_lui(addr_s);
        inst_valid_next_s = 1'b1;
      end
      ST_ADDA: begin
        inst_next_s       = enc_addi(ADDR_REG, ADDR_REG, addr_s[11:0]);
        inst_valid_next_s = 1'b1;
      end
      ST_ADDD: begin
        inst_next_s       = enc_addi(DATA_REG, 5'd0, {4'h0, wdata_s});
        inst_valid_next_s = 1'b1;
      end
      ST_MEM: begin
        inst_next_s       = write_s ? enc_sb() : enc_lb();
        inst_valid_next_s = 1'b1;
      end
      ST_JAL: begin
        inst_next_s       = enc_jal();
        inst_valid_next_s = 1'b1;
      end
      default: begin
        inst_next_s       = 32'h0000_0000;
        inst_valid_next_s = 1'b0;
      end
    endcase
  end

  // Response data: cleared on capture so writes report 0, loaded on read return.
  always_comb begin
    rdata_next_s = rdata_r;
    if (capture_s) begin
      rdata_next_s = 8'h00;
    end else if ((state_r == ST_WAIT) && core_rdata_valid) begin
      rdata_next_s = core_rdata;
    end else begin
      rdata_next_s = rdata_r;
    end
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 8'h00;
      write_r      <= 1'b0;
      rdata_r      <= 8'h00;
      req_ready_r  <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      if (capture_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        write_r <= req_write;
      end
      rdata_r      <= rdata_next_s;
      req_ready_r  <= (state_next_s == ST_IDLE);
      inst_valid_r <= inst_valid_next_s;
      inst_r       <= inst_next_s;
      resp_valid_r <= (state_next_s == ST_RESP);
      busy_r       <= (state_next_s != ST_IDLE);
    end
  end

  assign req_ready  = req_ready_r;
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = rdata_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ladybird_mem_access_seq.sv
module tb_ladybird_mem_access_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        core_rdata_valid;
  logic [7:0]  core_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_rdata;
  logic        busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] got_q[$];
  int          got_cyc;

  always #5 clk = ~clk;

  ladybird_mem_access_seq dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .core_rdata_valid(core_rdata_valid), .core_rdata(core_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .busy(busy)
  );

  // Present one request for one cycle; returns on the next falling edge.
  task automatic send_req(input logic wr, input logic [31:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Record accepted instructions until resp_valid or the cycle budget runs out.
  task automatic collect(input int budget);
    got_q.delete();
    got_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (resp_valid === 1'b1) break;
      if (inst_valid === 1'b1 && inst_ready === 1'b1) got_q.push_back(inst);
      @(negedge clk);
      got_cyc++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 8'h0;
    inst_ready = 1'b1; core_rdata_valid = 1'b0; core_rdata = 8'h0; resp_ready = 1'b0;
    #12;
    chk_cnt++;
    if ({inst_valid, resp_valid, busy} !== 3'b000 || inst !== 32'h0 || resp_rdata !== 8'h0)
      $display("FAIL reset_outputs: got iv=%b rv=%b busy=%b inst=%h rdata=%h required all 0",
               inst_valid, resp_valid, busy, inst, resp_rdata);
    else pass_cnt++;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got req_ready=%b busy=%b required 1/0", req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_write();
    logic [31:0] exp_w [5];
    logic [31:0] g;
    exp_w = '{32'h800012B7, 32'h23428293, 32'h0A500313, 32'h00628023, 32'h0000006F};
    send_req(1'b1, 32'h8000_1234, 8'hA5);
    collect(20);
    chk_cnt++;
    if (got_q.size() != 5) $display("FAIL write_count: got %0d required 5", got_q.size());
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      g = (k < got_q.size()) ? got_q[k] : 32'hxxxx_xxxx;
      chk_cnt++;
      if (g !== exp_w[k]) $display("FAIL write_inst%0d: got %h required %h", k, g, exp_w[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (got_cyc + 1 != 6) $display("FAIL write_latency: got %0d required 6", got_cyc + 1);
    else pass_cnt++;
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 8'h00 || req_ready !== 1'b0)
      $display("FAIL write_resp: got rv=%b rdata=%h req_ready=%b required 1/00/0",
               resp_valid, resp_rdata, req_ready);
    else pass_cnt++;
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    chk_cnt++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL write_done: got rv=%b req_ready=%b busy=%b required 0/1/0",
               resp_valid, req_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic [31:0] exp_r [4];
    logic [31:0] g;
    exp_r = '{32'h000012B7, 32'hFFF28293, 32'h00028303, 32'h0000006F};
    send_req(1'b0, 32'h0000_0FFF, 8'h00);
    collect(8);
    chk_cnt++;
    if (got_q.size() != 4) $display("FAIL read_count: got %0d required 4", got_q.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      g = (k < got_q.size()) ? got_q[k] : 32'hxxxx_xxxx;
      chk_cnt++;
      if (g !== exp_r[k]) $display("FAIL read_inst%0d: got %h required %h", k, g, exp_r[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (resp_valid !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL read_wait: got rv=%b iv=%b busy=%b required 0/0/1", resp_valid, inst_valid, busy);
    else pass_cnt++;
    core_rdata_valid = 1'b1; core_rdata = 8'h3C;
    @(negedge clk);
    core_rdata_valid = 1'b0; core_rdata = 8'h00;
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 8'h3C)
      $display("FAIL read_resp: got rv=%b rdata=%h required 1/3c", resp_valid, resp_rdata);
    else pass_cnt++;
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    chk_cnt++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL read_done: got rv=%b req_ready=%b required 0/1", resp_valid, req_ready);
    else pass_cnt++;
  endtask

  task automatic test_hi_wrap();
    send_req(1'b0, 32'hFFFF_F800, 8'h00);
    collect(8);
    chk_cnt++;
    if (got_q.size() < 2 || got_q[0] !== 32'h000002B7)
      $display("FAIL wrap_lui: got %h required 000002b7", got_q.size() > 0 ? got_q[0] : 32'hx);
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() < 2 || got_q[1] !== 32'h80028293)
      $display("FAIL wrap_addi: got %h required 80028293", got_q.size() > 1 ? got_q[1] : 32'hx);
    else pass_cnt++;
    core_rdata_valid = 1'b1; core_rdata = 8'h81;
    @(negedge clk);
    core_rdata_valid = 1'b0;
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 8'h81)
      $display("FAIL wrap_resp: got rv=%b rdata=%h required 1/81", resp_valid, resp_rdata);
    else pass_cnt++;
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_b [4];
    logic [31:0] g;
    exp_b = '{32'h23428293, 32'h0A500313, 32'h00628023, 32'h0000006F};
    send_req(1'b1, 32'h8000_1234, 8'hA5);
    chk_cnt++;
    if (inst !== 32'h800012B7 || inst_valid !== 1'b1)
      $display("FAIL bp_lui: got %h iv=%b required 800012b7/1", inst, inst_valid);
    else pass_cnt++;
    @(negedge clk);
    inst_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (inst !== 32'h23428293 || inst_valid !== 1'b1)
        $display("FAIL bp_hold%0d: got %h iv=%b required 23428293/1", c, inst, inst_valid);
      else pass_cnt++;
    end
    inst_ready = 1'b1;
    collect(12);
    chk_cnt++;
    if (got_q.size() != 4) $display("FAIL bp_count: got %0d required 4", got_q.size());
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      g = (k < got_q.size()) ? got_q[k] : 32'hxxxx_xxxx;
      chk_cnt++;
      if (g !== exp_b[k]) $display("FAIL bp_inst%0d: got %h required %h", k, g, exp_b[k]);
      else pass_cnt++;
    end
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_req(1'b1, 32'h8000_1234, 8'hA5);   // LUI shown
    @(negedge clk);                          // ADDA
    @(negedge clk);                          // ADDD
    @(negedge clk);                          // MEM
    chk_cnt++;
    if (inst !== 32'h00628023) $display("FAIL rst_mem_reached: got %h required 00628023", inst);
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    chk_cnt++;
    if ({inst_valid, resp_valid, busy} !== 3'b000 || inst !== 32'h0 || resp_rdata !== 8'h0)
      $display("FAIL rst_mid_outputs: got iv=%b rv=%b busy=%b inst=%h rdata=%h required all 0",
               inst_valid, resp_valid, busy, inst, resp_rdata);
    else pass_cnt++;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1 || inst_valid !== 1'b0)
      $display("FAIL rst_mid_release: got req_ready=%b iv=%b required 1/0", req_ready, inst_valid);
    else pass_cnt++;
    send_req(1'b0, 32'h0000_1000, 8'h00);
    chk_cnt++;
    if (inst !== 32'h000012B7 || inst_valid !== 1'b1)
      $display("FAIL rst_mid_lui: got %h iv=%b required 000012b7/1", inst, inst_valid);
    else pass_cnt++;
    collect(8);
    chk_cnt++;
    if (got_q.size() != 4 || got_q[1] !== 32'h00028293)
      $display("FAIL rst_mid_stream: got n=%0d required 4 with addi 00028293", got_q.size());
    else pass_cnt++;
    core_rdata_valid = 1'b1; core_rdata = 8'h5A;
    @(negedge clk);
    core_rdata_valid = 1'b0;
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 8'h5A)
      $display("FAIL rst_mid_resp: got rv=%b rdata=%h required 1/5a", resp_valid, resp_rdata);
    else pass_cnt++;
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
  endtask

  task automatic test_protocol();
    send_req(1'b1, 32'h0000_0040, 8'h11);
    collect(20);
    // Hold a new request while the response is stalled.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_2000;
    for (int c = 0; c < 3; c++) begin
      chk_cnt++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 || inst_valid !== 1'b0 || resp_rdata !== 8'h00)
        $display("FAIL proto_hold%0d: got req_ready=%b rv=%b iv=%b rdata=%h required 0/1/0/00",
                 c, req_ready, resp_valid, inst_valid, resp_rdata);
      else pass_cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL proto_no_capture: got busy=%b rv=%b req_ready=%b required 0/0/1",
               busy, resp_valid, req_ready);
    else pass_cnt++;
    core_rdata_valid = 1'b1; core_rdata = 8'h77;
    @(negedge clk);
    core_rdata_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL proto_spurious: got rv=%b busy=%b iv=%b required 0/0/0",
               resp_valid, busy, inst_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_hi_wrap();
    test_backpressure();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ladybird_mem_access_seq.md
Name: ladybird_mem_access_seq

Overview:
- Debug-side sequencer that turns a single-byte host memory request into a short RV32I instruction stream for the core's injected-fetch port.
- The stream builds the address in a scratch register and performs LB or SB.
- The stream ends with a JAL that returns control to the core.
- For reads, it waits for the byte the core reports back and returns it to the host. It sits between the host/debug request interface and the core instruction-injection input.

Parameters:
- ADDR_REG, 5, scratch register index that holds the target address (5 bits).
- DATA_REG, 6, scratch register index that holds the data byte (5 bits).
- JAL_OFFSET, 21'h0, JAL offset of the terminating instruction; bit 0 is forced to 0 in the encoding.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store byte (SB), 0 = load byte (LB).
- req_addr  in  32  byte address.
- req_wdata  in  8  store data.
- inst_valid  out  1  instruction valid toward the core.
- inst_ready  in  1  core accepts the instruction.
- inst  out  32  encoded RV32I instruction.
- core_rdata_valid  in  1  core reports the loaded byte.
- core_rdata  in  8  loaded byte, sign-extended value truncated by the core.
- resp_valid  out  1  response valid toward the host.
- resp_ready  in  1  host accepts the response.
- resp_rdata  out  8  read data; 0 for writes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1 after reset release.
  - inst_valid=0, inst=0, resp_valid=0, resp_rdata=0, busy=0.
  - Any sequence in progress is abandoned; no partial instruction is re-emitted after reset.
- Request capture: on req_valid & req_ready, latch addr, wdata and write, then go to LUI. Capture takes 1 cycle; inst_valid rises in the following cycle.
- Address split:
  - hi = req_addr[31:12] + req_addr[11], modulo 2^20 (wraps).
  - lo = req_addr[11:0].
  - The pair compensates for the sign extension of the ADDI immediate.
- States and emitted instructions (each state holds inst stable with inst_valid=1 until inst_ready, then advances):
  - LUI: LUI ADDR_REG, hi = {hi, ADDR_REG, 7'b0110111}.
  - ADDA: ADDI ADDR_REG, ADDR_REG, lo.
  - ADDD: ADDI DATA_REG, x0, {4'b0, wdata}. Write requests only; reads skip from ADDA to MEM.
  - MEM:
    - Write: SB, data=DATA_REG, base=ADDR_REG, offset 0 = {7'b0, DATA_REG, ADDR_REG, 3'b000, 5'b0, 7'b0100011}.
    - Read: LB DATA_REG, 0(ADDR_REG) = {12'b0, ADDR_REG, 3'b000, DATA_REG, 7'b0000011}.
  - JAL: JAL x0, JAL_OFFSET. Next state: reads go to WAIT; writes go to RESP with rdata=0.
  - WAIT: inst_valid=0. On core_rdata_valid, latch core_rdata and go to RESP. core_rdata_valid in any other state is ignored.
  - RESP: resp_valid=1 until resp_ready, then return to IDLE. req_ready stays 0 until that handshake completes. No back-to-back overlap.
- inst_valid must not drop, and inst must not change, while inst_ready=0 (AXI-style stability rule).
- Minimum latency with inst_ready and resp_ready tied high:
  - Write: 5 instruction cycles.
  - Read: 4 instruction cycles plus the core wait.
  - Measured request accept to resp_valid: 6 cycles for a write.

Test Plan:
- Write addr=0x8000_1234, wdata=0xA5, inst_ready=1 -> inst sequence is 0x800012B7, 0x23428293, 0x0A500313, 0x00628023, 0x0000006F. Then resp_valid=1 with resp_rdata=0x00.
- Read addr=0x0000_0FFF -> sequence 0x000012B7, 0xFFF28293, 0x00028303, 0x0000006F. Pulse core_rdata_valid with core_rdata=0x3C -> resp_rdata=0x3C.
- Hi wrap: read addr=0xFFFF_F800 -> first two instructions are 0x000002B7 and 0x80028293.
- Backpressure: hold inst_ready=0 for 3 cycles during ADDA -> inst stays 0x23428293 and inst_valid stays 1 throughout. No instruction is skipped or duplicated.
- Reset mid-sequence: assert rstn=0 in MEM -> all outputs are 0 immediately. After release, req_ready=1, and a new request emits LUI first.
- Protocol: req_valid held during RESP with resp_ready=0 -> req_ready=0 and no capture. A spurious core_rdata_valid in IDLE is ignored, and resp_valid stays 0.
